// File: rtl/pong_pkg.sv
// Shared definitions for the pong frame renderer: default geometry, grayscale
// palette, renderer state encoding and packed-coordinate field helpers.
package pong_pkg;

   localparam int DEF_BALL_SIZE = 4;
   localparam int DEF_PADDLE_W  = 4;
   localparam int DEF_PADDLE_H  = 32;

   localparam logic [7:0] COL_BG     = 8'h00;
   localparam logic [7:0] COL_PADDLE = 8'hC0;
   localparam logic [7:0] COL_BALL   = 8'hFF;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Packed coordinates and dimensions carry x/width high, y/height low.
   function automatic logic [15:0] pos_x(input logic [31:0] i_p);
      return i_p[31:16];
   endfunction

   function automatic logic [15:0] pos_y(input logic [31:0] i_p);
      return i_p[15:0];
   endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// Pixel stream from the renderer: one grayscale byte per transfer plus
// frame/row framing flags, with valid/ready flow control.
interface pong_renderer_if;
   logic [7:0] pixelOut;
   logic       pixelValid;
   logic       pixelReady;
   logic       pixelSof;
   logic       pixelEol;
   logic       pixelLast;

   modport master (
      output pixelOut, pixelValid, pixelSof, pixelEol, pixelLast,
      input  pixelReady
   );

   modport slave (
      input  pixelOut, pixelValid, pixelSof, pixelEol, pixelLast,
      output pixelReady
   );
endinterface

// File: rtl/pong_rect_hit.sv
// Combinational point-in-rectangle test; the far edges are formed in 17 bits
// so that objects placed near the top of the coordinate range never wrap.
module pong_rect_hit (
   input  logic [15:0] i_px,
   input  logic [15:0] i_py,
   input  logic [15:0] i_rx,
   input  logic [15:0] i_ry,
   input  logic [15:0] i_rw,
   input  logic [15:0] i_rh,
   output logic        o_hit
);

   logic [16:0] w_x_end;
   logic [16:0] w_y_end;
   logic        w_in_x;
   logic        w_in_y;

   assign w_x_end = {1'b0, i_rx} + {1'b0, i_rw};
   assign w_y_end = {1'b0, i_ry} + {1'b0, i_rh};
   assign w_in_x  = (i_px >= i_rx) && ({1'b0, i_px} < w_x_end);
   assign w_in_y  = (i_py >= i_ry) && ({1'b0, i_py} < w_y_end);
   assign o_hit   = w_in_x && w_in_y;

endmodule

// File: rtl/pong_renderer.sv
// Streams one frame of ball/paddle graphics in raster order. All outputs are
// registered, so the pixel for the next (x,y) is prepared one cycle ahead.
module pong_renderer
   import pong_pkg::*;
#(
   parameter int         BALL_SIZE    = DEF_BALL_SIZE,
   parameter int         PADDLE_W     = DEF_PADDLE_W,
   parameter int         PADDLE_H     = DEF_PADDLE_H,
   parameter logic [7:0] BG_COLOR     = COL_BG,
   parameter logic [7:0] PADDLE_COLOR = COL_PADDLE,
   parameter logic [7:0] BALL_COLOR   = COL_BALL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frameStart,
   input  logic [31:0]             dimensions,
   input  logic [31:0]             ballPosition,
   input  logic [31:0]             leftPaddlePosition,
   input  logic [31:0]             rightPaddlePosition,
   pong_renderer_if.master         pix,
   output logic                    busy,
   output logic                    frameDone
);

   localparam logic [15:0] L_BALL_SZ = 16'(BALL_SIZE);
   localparam logic [15:0] L_PAD_W   = 16'(PADDLE_W);
   localparam logic [15:0] L_PAD_H   = 16'(PADDLE_H);

   state_t      r_state;
   logic [15:0] r_w;
   logic [15:0] r_h;
   logic [31:0] r_ball;
   logic [31:0] r_lpad;
   logic [31:0] r_rpad;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic [7:0]  r_pixel;
   logic        r_valid;
   logic        r_sof;
   logic        r_eol;
   logic        r_last;
   logic        r_busy;
   logic        r_done;

   state_t      w_next_state;
   logic        w_latch;
   logic        w_done_next;
   logic [15:0] w_nx;
   logic [15:0] w_ny;
   logic [15:0] w_w;
   logic [15:0] w_h;
   logic [31:0] w_ball;
   logic [31:0] w_lpad;
   logic [31:0] w_rpad;
   logic        w_hit_ball;
   logic        w_hit_lpad;
   logic        w_hit_rpad;
   logic [7:0]  w_n_pixel;
   logic        w_n_sof;
   logic        w_n_eol;
   logic        w_n_last;

   // Next raster position and state; a frame start sources geometry straight
   // from the inputs so the first pixel uses the values being snapshotted.
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_done_next  = 1'b0;
      w_nx         = r_x;
      w_ny         = r_y;
      w_w          = r_w;
      w_h          = r_h;
      w_ball       = r_ball;
      w_lpad       = r_lpad;
      w_rpad       = r_rpad;
      case (r_state)
         ST_IDLE: begin
            if (frameStart) begin
               w_latch = 1'b1;
               w_w     = pos_x(dimensions);
               w_h     = pos_y(dimensions);
               w_ball  = ballPosition;
               w_lpad  = leftPaddlePosition;
               w_rpad  = rightPaddlePosition;
               w_nx    = 16'd0;
               w_ny    = 16'd0;
               if ((w_w == 16'd0) || (w_h == 16'd0)) begin
                  w_done_next = 1'b1;
               end else begin
                  w_next_state = ST_ACTIVE;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (pix.pixelReady) begin
               if (r_x == (r_w - 16'd1)) begin
                  w_nx = 16'd0;
                  if (r_y == (r_h - 16'd1)) begin
                     w_next_state = ST_IDLE;
                     w_done_next  = 1'b1;
                  end else begin
                     w_ny = r_y + 16'd1;
                  end
               end else begin
                  w_nx = r_x + 16'd1;
               end
            end else begin
               w_next_state = ST_ACTIVE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   pong_rect_hit u_hit_ball (
      .i_px (w_nx),             .i_py (w_ny),
      .i_rx (pos_x(w_ball)),    .i_ry (pos_y(w_ball)),
      .i_rw (L_BALL_SZ),        .i_rh (L_BALL_SZ),
      .o_hit(w_hit_ball)
   );

   pong_rect_hit u_hit_lpad (
      .i_px (w_nx),             .i_py (w_ny),
      .i_rx (pos_x(w_lpad)),    .i_ry (pos_y(w_lpad)),
      .i_rw (L_PAD_W),          .i_rh (L_PAD_H),
      .o_hit(w_hit_lpad)
   );

   pong_rect_hit u_hit_rpad (
      .i_px (w_nx),             .i_py (w_ny),
      .i_rx (pos_x(w_rpad)),    .i_ry (pos_y(w_rpad)),
      .i_rw (L_PAD_W),          .i_rh (L_PAD_H),
      .o_hit(w_hit_rpad)
   );

   // Colour priority: ball over paddles over background.
   always_comb begin
      if (w_hit_ball) begin
         w_n_pixel = BALL_COLOR;
      end else if (w_hit_lpad || w_hit_rpad) begin
         w_n_pixel = PADDLE_COLOR;
      end else begin
         w_n_pixel = BG_COLOR;
      end
   end

   assign w_n_sof  = (w_nx == 16'd0) && (w_ny == 16'd0);
   assign w_n_eol  = (w_nx == (w_w - 16'd1));
   assign w_n_last = w_n_eol && (w_ny == (w_h - 16'd1));

   // State, counters, snapshots and registered stream outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_w     <= 16'd0;
         r_h     <= 16'd0;
         r_ball  <= 32'd0;
         r_lpad  <= 32'd0;
         r_rpad  <= 32'd0;
         r_x     <= 16'd0;
         r_y     <= 16'd0;
         r_pixel <= 8'h00;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_x     <= w_nx;
         r_y     <= w_ny;
         r_done  <= w_done_next;
         if (w_latch) begin
            r_w    <= w_w;
            r_h    <= w_h;
            r_ball <= w_ball;
            r_lpad <= w_lpad;
            r_rpad <= w_rpad;
         end
         if (w_next_state == ST_ACTIVE) begin
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_pixel <= w_n_pixel;
            r_sof   <= w_n_sof;
            r_eol   <= w_n_eol;
            r_last  <= w_n_last;
         end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_pixel <= 8'h00;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   assign pix.pixelOut   = r_pixel;
   assign pix.pixelValid = r_valid;
   assign pix.pixelSof   = r_sof;
   assign pix.pixelEol   = r_eol;
   assign pix.pixelLast  = r_last;
   assign busy           = r_busy;
   assign frameDone      = r_done;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer with a raster-level reference model that
// predicts every output on every cycle, plus hand-computed pixel/count checks.
module tb_pong_renderer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frameStart = 1'b0;
   logic [31:0] dimensions = 32'd0;
   logic [31:0] ballPosition = 32'd0;
   logic [31:0] leftPaddlePosition = 32'd0;
   logic [31:0] rightPaddlePosition = 32'd0;
   logic        busy;
   logic        frameDone;

   pong_renderer_if pif ();

   pong_renderer dut (
      .clk                 (clk),
      .rst                 (rst),
      .frameStart          (frameStart),
      .dimensions          (dimensions),
      .ballPosition        (ballPosition),
      .leftPaddlePosition  (leftPaddlePosition),
      .rightPaddlePosition (rightPaddlePosition),
      .pix                 (pif),
      .busy                (busy),
      .frameDone           (frameDone)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_on = 1'b0;
   bit m_done = 1'b0;
   int mx, my, mW, mH, mbx, mby, mlx, mly, mrx, mry;

   // observed stream statistics
   int n_xfer, n_sof, n_eol, n_last;
   logic [7:0] cap[$];
   logic [7:0] ref_cap[$];

   bit         p_stall = 1'b0;
   logic [10:0] p_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit in_rect(int x, int y, int rx, int ry, int w, int h);
      return (x >= rx) && (x < rx + w) && (y >= ry) && (y < ry + h);
   endfunction

   function automatic logic [7:0] model_pix(int x, int y);
      if (in_rect(x, y, mbx, mby, 4, 4)) return 8'hFF;
      if (in_rect(x, y, mlx, mly, 4, 32) || in_rect(x, y, mrx, mry, 4, 32)) return 8'hC0;
      return 8'h00;
   endfunction

   // Per-cycle comparison against the model, then advance the model using the
   // inputs that the coming rising edge will sample.
   always @(negedge clk) begin
      chk("valid", 32'(pif.pixelValid), 32'(m_on));
      chk("busy", 32'(busy), 32'(m_on));
      chk("frameDone", 32'(frameDone), 32'(m_done));
      if (m_on) begin
         chk("pixel", 32'(pif.pixelOut), 32'(model_pix(mx, my)));
         chk("sof", 32'(pif.pixelSof), 32'((mx == 0) && (my == 0)));
         chk("eol", 32'(pif.pixelEol), 32'(mx == mW - 1));
         chk("last", 32'(pif.pixelLast), 32'((mx == mW - 1) && (my == mH - 1)));
      end else begin
         chk("flags_idle", 32'({pif.pixelSof, pif.pixelEol, pif.pixelLast}), 32'd0);
      end
      if (p_stall) begin
         chk("stall_hold", 32'({pif.pixelOut, pif.pixelSof, pif.pixelEol, pif.pixelLast}), 32'(p_out));
      end
      p_stall = rst && pif.pixelValid && !pif.pixelReady;
      p_out   = {pif.pixelOut, pif.pixelSof, pif.pixelEol, pif.pixelLast};

      if (!rst) begin
         m_on   = 1'b0;
         m_done = 1'b0;
      end else if (m_on) begin
         m_done = 1'b0;
         if (pif.pixelReady) begin
            n_xfer++;
            n_sof  += int'(pif.pixelSof);
            n_eol  += int'(pif.pixelEol);
            n_last += int'(pif.pixelLast);
            cap.push_back(pif.pixelOut);
            if ((mx == mW - 1) && (my == mH - 1)) begin
               m_on   = 1'b0;
               m_done = 1'b1;
            end else if (mx == mW - 1) begin
               mx = 0;
               my = my + 1;
            end else begin
               mx = mx + 1;
            end
         end
      end else if (frameStart) begin
         mW  = int'(dimensions[31:16]);
         mH  = int'(dimensions[15:0]);
         mbx = int'(ballPosition[31:16]);
         mby = int'(ballPosition[15:0]);
         mlx = int'(leftPaddlePosition[31:16]);
         mly = int'(leftPaddlePosition[15:0]);
         mrx = int'(rightPaddlePosition[31:16]);
         mry = int'(rightPaddlePosition[15:0]);
         mx  = 0;
         my  = 0;
         if ((mW == 0) || (mH == 0)) begin
            m_done = 1'b1;
         end else begin
            m_on   = 1'b1;
            m_done = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      n_xfer = 0; n_sof = 0; n_eol = 0; n_last = 0;
      cap.delete();
   endtask

   task automatic start_frame(input logic [15:0] w, input logic [15:0] h,
                              input logic [31:0] b, input logic [31:0] l, input logic [31:0] r);
      dimensions          = {w, h};
      ballPosition        = b;
      leftPaddlePosition  = l;
      rightPaddlePosition = r;
      frameStart          = 1'b1;
      tick(1);
      frameStart          = 1'b0;
   endtask

   // Wait (bounded) for frameDone, optionally toggling pixelReady randomly.
   task automatic wait_done(input string name, input bit rnd);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (rnd) pif.pixelReady = 1'($urandom_range(0, 1));
      end while ((frameDone !== 1'b1) && (k < 3000));
      pif.pixelReady = 1'b1;
      chk(name, 32'(frameDone), 32'd1);
   endtask

   localparam logic [31:0] OFF = {16'hFFF0, 16'hFFF0};

   initial begin
      int diff;
      int ff_cnt;
      pif.pixelReady = 1'b1;
      clear_stats();
      tick(2);
      @(negedge clk);
      chk("rst_pixel", 32'(pif.pixelOut), 32'h00);
      chk("rst_valid", 32'(pif.pixelValid), 32'd0);
      chk("rst_flags", 32'({pif.pixelSof, pif.pixelEol, pif.pixelLast}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frameDone), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick(1);

      // 8x4 frame at full throughput
      clear_stats();
      start_frame(16'd8, 16'd4, OFF, OFF, OFF);
      wait_done("done_8x4", 1'b0);
      chk("xfer_8x4", 32'(n_xfer), 32'd32);
      chk("sof_8x4", 32'(n_sof), 32'd1);
      chk("eol_8x4", 32'(n_eol), 32'd4);
      chk("last_8x4", 32'(n_last), 32'd1);

      // colour priority 16x16
      clear_stats();
      start_frame(16'd16, 16'd16, {16'd2, 16'd2}, {16'd0, 16'd0}, {16'd12, 16'd0});
      wait_done("done_col", 1'b0);
      chk("col_len", 32'(cap.size()), 32'd256);
      if (cap.size() == 256) begin
         chk("col_3_3", 32'(cap[3*16+3]), 32'hFF);
         chk("col_0_10", 32'(cap[10*16+0]), 32'hC0);
         chk("col_12_5", 32'(cap[5*16+12]), 32'hC0);
         chk("col_6_6", 32'(cap[6*16+6]), 32'h00);
         chk("col_2_2", 32'(cap[2*16+2]), 32'hFF);
      end
      ref_cap = cap;

      // same frame under random backpressure
      clear_stats();
      start_frame(16'd16, 16'd16, {16'd2, 16'd2}, {16'd0, 16'd0}, {16'd12, 16'd0});
      pif.pixelReady = 1'b0;
      wait_done("done_bp", 1'b1);
      diff = 0;
      for (int i = 0; i < 256; i++) begin
         if ((i >= cap.size()) || (i >= ref_cap.size()) || (cap[i] !== ref_cap[i])) diff++;
      end
      chk("bp_bytes_diff", 32'(diff), 32'd0);

      // clipping near the top of the coordinate range: nothing drawn
      clear_stats();
      start_frame(16'd10, 16'd10, {16'hFFFE, 16'd8}, OFF, OFF);
      wait_done("done_clip1", 1'b0);
      ff_cnt = 0;
      foreach (cap[i]) if (cap[i] == 8'hFF) ff_cnt++;
      chk("clip_wrap_ff", 32'(ff_cnt), 32'd0);

      // ball partly outside: only 2x2 visible in the corner
      clear_stats();
      start_frame(16'd10, 16'd10, {16'd8, 16'd8}, OFF, OFF);
      wait_done("done_clip2", 1'b0);
      ff_cnt = 0;
      foreach (cap[i]) if (cap[i] == 8'hFF) ff_cnt++;
      chk("clip_ff_cnt", 32'(ff_cnt), 32'd4);
      if (cap.size() == 100) begin
         chk("clip_8_8", 32'(cap[88]), 32'hFF);
         chk("clip_9_9", 32'(cap[99]), 32'hFF);
      end

      // zero width: immediate completion, no pixels
      start_frame(16'd0, 16'd4, OFF, OFF, OFF);
      chk("zero_done", 32'(frameDone), 32'd1);
      chk("zero_valid", 32'(pif.pixelValid), 32'd0);
      tick(1);
      chk("zero_done_off", 32'(frameDone), 32'd0);

      // frameStart held: one frame, then a new one begins on the done cycle
      clear_stats();
      dimensions = {16'd4, 16'd2};
      frameStart = 1'b1;
      tick(1);
      wait_done("done_held1", 1'b0);
      chk("held_sof1", 32'(n_sof), 32'd1);
      chk("held_xfer1", 32'(n_xfer), 32'd8);
      tick(1);
      chk("held_restart_valid", 32'(pif.pixelValid), 32'd1);
      chk("held_restart_sof", 32'(pif.pixelSof), 32'd1);
      frameStart = 1'b0;
      wait_done("done_held2", 1'b0);
      chk("held_xfer2", 32'(n_xfer), 32'd16);

      // reset in the middle of a frame
      clear_stats();
      start_frame(16'd8, 16'd4, OFF, OFF, OFF);
      for (int k = 0; (k < 100) && (n_xfer < 5); k++) tick(1);
      chk("mid_xfer", 32'(n_xfer), 32'd5);
      rst = 1'b0;
      tick(1);
      chk("mid_valid", 32'(pif.pixelValid), 32'd0);
      rst = 1'b1;
      tick(3);
      chk("mid_no_done", 32'(frameDone), 32'd0);
      chk("mid_idle", 32'(pif.pixelValid), 32'd0);
      start_frame(16'd8, 16'd4, OFF, OFF, OFF);
      chk("mid_new_valid", 32'(pif.pixelValid), 32'd1);
      chk("mid_new_sof", 32'(pif.pixelSof), 32'd1);
      wait_done("done_mid", 1'b0);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
